wb_unified_mem_ctrl: RTL and testbench

//   Wishbone classic slave sitting directly below custom_riscv_core. Merges the core's instruction
//   (iwb) and data (dwb) buses onto one single-port synchronous SRAM (unified code+data, so

---
 rtl/wb_unified_mem_ctrl_pkg.sv | 34 +++
 rtl/wb_unified_mem_ctrl_if.sv | 34 +++
 rtl/wb_unified_mem_ctrl_arb.sv | 41 ++++
 rtl/wb_unified_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_wb_unified_mem_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_unified_mem_ctrl_pkg.sv
// Shared definitions for the unified instruction/data memory controller.
//   state_t   : controller FSM states (IDLE -> ACCESS -> RESP)
//   grant_t   : which Wishbone port owns the current access
//   NOP_WORD_DEFAULT    : word returned for out-of-range instruction fetches
//   TOHOST_WORD_DEFAULT : word index of the compliance tohost location
//   sel_merge : byte-lane merge of a new word into an old word
package wb_unified_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  localparam logic [31:0] NOP_WORD_DEFAULT    = 32'h0000_0013;
  localparam int unsigned TOHOST_WORD_DEFAULT = 2048;

  function automatic logic [31:0] sel_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_unified_mem_ctrl_if.sv
// Wishbone classic bundle carrying both core buses (iwb fetch, dwb data).
//   master : core side (drives adr/cyc/stb/we/sel/dat_i, receives dat_o/ack/err)
//   slave  : memory controller side
interface wb_unified_mem_ctrl_if;
  logic [31:0] iwb_adr_i;
  logic        iwb_cyc_i;
  logic        iwb_stb_i;
  logic [31:0] iwb_dat_o;
  logic        iwb_ack_o;

  logic [31:0] dwb_adr_i;
  logic [31:0] dwb_dat_i;
  logic        dwb_we_i;
  logic [3:0]  dwb_sel_i;
  logic        dwb_cyc_i;
  logic        dwb_stb_i;
  logic [31:0] dwb_dat_o;
  logic        dwb_ack_o;
  logic        dwb_err_o;

  modport master (
    output iwb_adr_i, iwb_cyc_i, iwb_stb_i,
    input  iwb_dat_o, iwb_ack_o,
    output dwb_adr_i, dwb_dat_i, dwb_we_i, dwb_sel_i, dwb_cyc_i, dwb_stb_i,
    input  dwb_dat_o, dwb_ack_o, dwb_err_o
  );

  modport slave (
    input  iwb_adr_i, iwb_cyc_i, iwb_stb_i,
    output iwb_dat_o, iwb_ack_o,
    input  dwb_adr_i, dwb_dat_i, dwb_we_i, dwb_sel_i, dwb_cyc_i, dwb_stb_i,
    output dwb_dat_o, dwb_ack_o, dwb_err_o
  );
endinterface

// File: rtl/wb_unified_mem_ctrl_arb.sv
// Two-requester arbiter (instruction vs data) for the unified memory.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_instr  : fetch port requesting
//   req_data   : data port requesting
//   take       : controller is able to accept a grant this cycle
//   valid      : at least one requester present
//   grant      : selected requester (combinational)
// Ties go to DATA unless DATA won the previous grant, so contention alternates.
module wb_rr_arbiter2
  import wb_unified_mem_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_instr,
  input  logic   req_data,
  input  logic   take,
  output logic   valid,
  output grant_t grant
);

  grant_t last_grant;

  always_comb begin
    valid = req_instr | req_data;
    grant = GRANT_INSTR;
    if (req_instr && req_data) begin
      grant = (last_grant == GRANT_DATA) ? GRANT_INSTR : GRANT_DATA;
    end else if (req_data) begin
      grant = GRANT_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_INSTR;
    end else if (take && valid) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/wb_unified_mem_ctrl.sv
// Wishbone classic slave merging the core's fetch and data buses onto one
// single-port synchronous SRAM, with byte selects, out-of-range detection and
// compliance tohost decoding.
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus           : iwb/dwb Wishbone signals (slave modport)
//   mem_en/we/addr/wdata/rdata : external SRAM port (rdata valid 1 cycle after mem_en)
//   tohost_valid  : 1-cycle pulse on nonzero tohost write
//   tohost_data   : last value written to tohost
//   test_pass/fail: sticky compliance result
module wb_unified_mem_ctrl
  import wb_unified_mem_ctrl_pkg::*;
#(
  parameter int unsigned AW          = 13,
  parameter int unsigned TOHOST_WORD = TOHOST_WORD_DEFAULT,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wb_unified_mem_ctrl_if.slave   bus,
  output logic                   mem_en,
  output logic [3:0]             mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic                   tohost_valid,
  output logic [31:0]            tohost_data,
  output logic                   test_pass,
  output logic                   test_fail
);

  state_t        state, state_n;
  grant_t        grant, r_gnt;
  logic          arb_valid;
  logic          req_instr, req_data;
  logic [31:0]   sel_adr;
  logic [AW-1:0] r_waddr;
  logic          r_we, r_in_range, r_drop;
  logic [3:0]    r_sel;
  logic [31:0]   r_wdata;
  logic          iwb_ack_q, dwb_ack_q, dwb_err_q;
  logic [31:0]   iwb_dat_q, dwb_dat_q;
  logic          hit_tohost;
  logic [31:0]   tohost_merged;
  logic          unused_adr_bits;

  assign unused_adr_bits = ^{bus.iwb_adr_i[1:0], bus.dwb_adr_i[1:0]};

  // Masters keep stb high during the ack cycle; masking a port while its own
  // response is showing stops that stale strobe from starting a second access.
  assign req_instr = bus.iwb_cyc_i & bus.iwb_stb_i & ~iwb_ack_q;
  assign req_data  = bus.dwb_cyc_i & bus.dwb_stb_i & ~(dwb_ack_q | dwb_err_q);

  wb_rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_instr (req_instr),
    .req_data  (req_data),
    .take      (state == ST_IDLE),
    .valid     (arb_valid),
    .grant     (grant)
  );

  assign sel_adr = (grant == GRANT_DATA) ? bus.dwb_adr_i : bus.iwb_adr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = r_waddr;
    mem_wdata = r_wdata;
    case (state)
      ST_IDLE:   if (arb_valid) state_n = ST_ACCESS;
      ST_ACCESS: begin
        state_n = ST_RESP;
        mem_en  = r_in_range;
        if (r_in_range && r_gnt == GRANT_DATA && r_we) mem_we = r_sel;
      end
      ST_RESP:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Request capture at grant; cyc is re-checked during ACCESS so an abandoned
  // cycle still completes its SRAM access but produces no response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt      <= GRANT_INSTR;
      r_waddr    <= '0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_wdata    <= '0;
      r_in_range <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      if (state == ST_IDLE && arb_valid) begin
        r_gnt      <= grant;
        r_waddr    <= sel_adr[AW+1:2];
        r_in_range <= (sel_adr[31:AW+2] == '0);
        r_we       <= (grant == GRANT_DATA) & bus.dwb_we_i;
        r_sel      <= bus.dwb_sel_i;
        r_wdata    <= bus.dwb_dat_i;
        r_drop     <= 1'b0;
      end
      if (state == ST_ACCESS) begin
        r_drop <= (r_gnt == GRANT_DATA) ? ~bus.dwb_cyc_i : ~bus.iwb_cyc_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iwb_ack_q <= 1'b0;
      dwb_ack_q <= 1'b0;
      dwb_err_q <= 1'b0;
      iwb_dat_q <= '0;
      dwb_dat_q <= '0;
    end else begin
      iwb_ack_q <= 1'b0;
      dwb_ack_q <= 1'b0;
      dwb_err_q <= 1'b0;
      if (state == ST_RESP && !r_drop) begin
        if (r_gnt == GRANT_INSTR) begin
          iwb_ack_q <= 1'b1;
          iwb_dat_q <= r_in_range ? mem_rdata : NOP_WORD;
        end else if (r_in_range) begin
          dwb_ack_q <= 1'b1;
          dwb_dat_q <= mem_rdata;
        end else begin
          dwb_err_q <= 1'b1;
          dwb_dat_q <= '0;
        end
      end
    end
  end

  assign bus.iwb_ack_o = iwb_ack_q;
  assign bus.iwb_dat_o = iwb_dat_q;
  assign bus.dwb_ack_o = dwb_ack_q;
  assign bus.dwb_err_o = dwb_err_q;
  assign bus.dwb_dat_o = dwb_dat_q;

  assign hit_tohost = (state == ST_RESP) && (r_gnt == GRANT_DATA) && r_we &&
                      r_in_range && (r_waddr == AW'(TOHOST_WORD));
  assign tohost_merged = sel_merge(tohost_data, r_wdata, r_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
      test_pass    <= 1'b0;
      test_fail    <= 1'b0;
    end else begin
      tohost_valid <= 1'b0;
      if (hit_tohost) begin
        tohost_data <= tohost_merged;
        if (tohost_merged != '0) begin
          tohost_valid <= 1'b1;
          if (tohost_merged == 32'd1) test_pass <= 1'b1;
          else                        test_fail <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_unified_mem_ctrl.sv
module tb_wb_unified_mem_ctrl;

  typedef struct {
    bit          is_data;
    bit          err;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        tohost_valid;
  logic [31:0] tohost_data;
  logic        test_pass, test_fail;

  int compared   = 0;
  int mismatched = 0;
  int en_cnt = 0, tv_cnt = 0, resp_cnt = 0;
  logic [3:0] last_we = '0;

  exp_t sb[$];
  exp_t e_mon;
  logic [31:0] sram [0:8191];

  wb_unified_mem_ctrl_if bus ();

  wb_unified_mem_ctrl #(.AW(13), .TOHOST_WORD(2048), .NOP_WORD(32'h13)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .tohost_valid (tohost_valid),
    .tohost_data  (tohost_data),
    .test_pass    (test_pass),
    .test_fail    (test_fail)
  );

  always #5 clk = ~clk;

  // behavioural single-port SRAM, read-before-write
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= sram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // scoreboard: every response pops the oldest expectation
  always @(negedge clk) begin
    if (mem_en) en_cnt++;
    if (mem_we != 4'b0) last_we = mem_we;
    if (tohost_valid) tv_cnt++;
    if (bus.iwb_ack_o || bus.dwb_ack_o || bus.dwb_err_o) begin
      resp_cnt++;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_resp: iwb_ack=%b dwb_ack=%b dwb_err=%b, required no response",
                 bus.iwb_ack_o, bus.dwb_ack_o, bus.dwb_err_o);
      end else begin
        e_mon = sb.pop_front();
        if ({bus.dwb_ack_o | bus.dwb_err_o, bus.dwb_err_o, bus.iwb_ack_o} !==
            {e_mon.is_data, e_mon.err, !e_mon.is_data} ||
            (e_mon.chk && ((e_mon.is_data ? bus.dwb_dat_o : bus.iwb_dat_o) !== e_mon.data))) begin
          mismatched++;
          $display("FAIL resp: got iwb_ack=%b dwb_ack=%b err=%b idat=%h ddat=%h, required data_port=%b err=%b dat=%h",
                   bus.iwb_ack_o, bus.dwb_ack_o, bus.dwb_err_o, bus.iwb_dat_o, bus.dwb_dat_o,
                   e_mon.is_data, e_mon.err, e_mon.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push(input bit is_data, input bit err, input bit chk, input logic [31:0] d);
    exp_t x;
    x.is_data = is_data; x.err = err; x.chk = chk; x.data = d;
    sb.push_back(x);
  endtask

  task automatic do_iwb(input logic [31:0] adr, output int lat);
    bus.iwb_adr_i = adr; bus.iwb_cyc_i = 1'b1; bus.iwb_stb_i = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.iwb_ack_o) begin lat = i; break; end
    end
    compared++;
    if (lat == 0) begin
      mismatched++;
      $display("FAIL iwb_timeout: no ack after 20 cycles, required ack");
    end
    @(negedge clk);
    bus.iwb_cyc_i = 1'b0; bus.iwb_stb_i = 1'b0;
  endtask

  task automatic do_dwb(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, output int lat);
    bus.dwb_adr_i = adr; bus.dwb_we_i = we; bus.dwb_sel_i = sel; bus.dwb_dat_i = dat;
    bus.dwb_cyc_i = 1'b1; bus.dwb_stb_i = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.dwb_ack_o || bus.dwb_err_o) begin lat = i; break; end
    end
    compared++;
    if (lat == 0) begin
      mismatched++;
      $display("FAIL dwb_timeout: no ack/err after 20 cycles, required response");
    end
    @(negedge clk);
    bus.dwb_cyc_i = 1'b0; bus.dwb_stb_i = 1'b0; bus.dwb_we_i = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int en0;
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus.iwb_ack_o, bus.dwb_ack_o, bus.dwb_err_o, mem_en, mem_we, tohost_valid, test_pass, test_fail} !== 11'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got acks/err/en/we/tv/pass/fail=%b, required all 0",
               {bus.iwb_ack_o, bus.dwb_ack_o, bus.dwb_err_o, mem_en, mem_we, tohost_valid, test_pass, test_fail});
    end
    compared++;
    if ({tohost_data, bus.iwb_dat_o, bus.dwb_dat_o} !== 96'b0) begin
      mismatched++;
      $display("FAIL reset_data: got tohost=%h idat=%h ddat=%h, required 0", tohost_data, bus.iwb_dat_o, bus.dwb_dat_o);
    end
    rst_n = 1'b1;
    en0 = en_cnt;
    repeat (4) @(negedge clk);
    compared++;
    if (en_cnt - en0 !== 0) begin
      mismatched++;
      $display("FAIL reset_idle_en: got %0d mem_en cycles, required 0", en_cnt - en0);
    end
  endtask

  task automatic test_fetch();
    int lat;
    sram[13'h10] = 32'hDEAD_BEEF;
    push(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    do_iwb(32'h0000_0040, lat);
    compared++;
    if (lat !== 3) begin
      mismatched++;
      $display("FAIL fetch_latency: got %0d, required 3", lat);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (bus.iwb_dat_o !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL fetch_hold: got %h, required deadbeef", bus.iwb_dat_o);
    end
  endtask

  task automatic test_byte_write();
    int lat;
    sram[13'h40] = 32'h1122_3344;
    last_we = '0;
    push(1'b1, 1'b0, 1'b0, 32'h0);
    do_dwb(32'h0000_0100, 1'b1, 4'b0010, 32'h0000_AB00, lat);
    compared++;
    if (last_we !== 4'b0010) begin
      mismatched++;
      $display("FAIL byte_we: got %b, required 0010", last_we);
    end
    compared++;
    if (sram[13'h40] !== 32'h1122_AB44) begin
      mismatched++;
      $display("FAIL byte_mem: got %h, required 1122ab44", sram[13'h40]);
    end
    push(1'b1, 1'b0, 1'b1, 32'h1122_AB44);
    do_dwb(32'h0000_0100, 1'b0, 4'b1111, 32'h0, lat);
  endtask

  task automatic test_contention();
    int li, ld;
    sram[13'h20] = 32'hA000_0001;
    sram[13'h21] = 32'hB000_0002;
    // make last_grant INSTR, then contend: data first
    push(1'b0, 1'b0, 1'b1, 32'hA000_0001);
    do_iwb(32'h0000_0080, li);
    push(1'b1, 1'b0, 1'b1, 32'hB000_0002);
    push(1'b0, 1'b0, 1'b1, 32'hA000_0001);
    fork
      do_iwb(32'h0000_0080, li);
      do_dwb(32'h0000_0084, 1'b0, 4'b1111, 32'h0, ld);
    join
    compared++;
    if (!(ld < li)) begin
      mismatched++;
      $display("FAIL contention_instr_last: got dwb lat %0d iwb lat %0d, required dwb first", ld, li);
    end
    // make last_grant DATA, then contend: instr first
    push(1'b1, 1'b0, 1'b1, 32'hB000_0002);
    do_dwb(32'h0000_0084, 1'b0, 4'b1111, 32'h0, ld);
    push(1'b0, 1'b0, 1'b1, 32'hA000_0001);
    push(1'b1, 1'b0, 1'b1, 32'hB000_0002);
    fork
      do_iwb(32'h0000_0080, li);
      do_dwb(32'h0000_0084, 1'b0, 4'b1111, 32'h0, ld);
    join
    compared++;
    if (!(li < ld) || ld !== 6) begin
      mismatched++;
      $display("FAIL contention_data_last: got iwb lat %0d dwb lat %0d, required iwb 3 then dwb 6", li, ld);
    end
  endtask

  task automatic test_tohost();
    int lat, tv0;
    tv0 = tv_cnt;
    push(1'b1, 1'b0, 1'b0, 32'h0);
    do_dwb(32'h0000_2000, 1'b1, 4'b1111, 32'd1, lat);
    compared++;
    if ({tv_cnt - tv0, test_pass, test_fail} !== {32'd1, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL tohost_pass: got pulses=%0d pass=%b fail=%b, required 1/1/0", tv_cnt - tv0, test_pass, test_fail);
    end
    pulse_reset();
    compared++;
    if ({test_pass, tohost_data} !== 33'b0) begin
      mismatched++;
      $display("FAIL tohost_reset: got pass=%b data=%h, required 0/0", test_pass, tohost_data);
    end
    tv0 = tv_cnt;
    push(1'b1, 1'b0, 1'b0, 32'h0);
    do_dwb(32'h0000_2000, 1'b1, 4'b1111, 32'd7, lat);
    compared++;
    if ({tv_cnt - tv0, test_pass, test_fail, tohost_data} !== {32'd1, 1'b0, 1'b1, 32'd7}) begin
      mismatched++;
      $display("FAIL tohost_fail: got pulses=%0d pass=%b fail=%b data=%h, required 1/0/1/7",
               tv_cnt - tv0, test_pass, test_fail, tohost_data);
    end
    push(1'b1, 1'b0, 1'b0, 32'h0);
    do_dwb(32'h0000_2000, 1'b1, 4'b0010, 32'h0000_0500, lat);
    compared++;
    if (tohost_data !== 32'h0000_0507) begin
      mismatched++;
      $display("FAIL tohost_merge: got %h, required 00000507", tohost_data);
    end
    tv0 = tv_cnt;
    push(1'b1, 1'b0, 1'b0, 32'h0);
    do_dwb(32'h0000_2000, 1'b1, 4'b1111, 32'd0, lat);
    compared++;
    if ({tv_cnt - tv0, tohost_data} !== {32'd0, 32'd0}) begin
      mismatched++;
      $display("FAIL tohost_zero: got pulses=%0d data=%h, required 0/0", tv_cnt - tv0, tohost_data);
    end
  endtask

  task automatic test_error_abort();
    int lat, en0, r0;
    en0 = en_cnt;
    push(1'b1, 1'b1, 1'b1, 32'h0);
    do_dwb(32'h0001_0000, 1'b0, 4'b1111, 32'h0, lat);
    compared++;
    if ({en_cnt - en0, lat} !== {32'd0, 32'd3}) begin
      mismatched++;
      $display("FAIL err_dwb: got en_cycles=%0d lat=%0d, required 0/3", en_cnt - en0, lat);
    end
    push(1'b0, 1'b0, 1'b1, 32'h0000_0013);
    do_iwb(32'h0010_0000, lat);
    // reset during ACCESS of a write
    sram[13'h14] = 32'hAAAA_5555;
    r0 = resp_cnt;
    bus.dwb_adr_i = 32'h0000_0050; bus.dwb_we_i = 1'b1; bus.dwb_sel_i = 4'hF;
    bus.dwb_dat_i = 32'h1234_5678; bus.dwb_cyc_i = 1'b1; bus.dwb_stb_i = 1'b1;
    @(negedge clk);
    compared++;
    if (mem_we !== 4'hF) begin
      mismatched++;
      $display("FAIL abort_access_we: got %b, required 1111", mem_we);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({mem_we, mem_en} !== 5'b0) begin
      mismatched++;
      $display("FAIL abort_we: got we=%b en=%b, required 0", mem_we, mem_en);
    end
    bus.dwb_cyc_i = 1'b0; bus.dwb_stb_i = 1'b0; bus.dwb_we_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    compared++;
    if ({resp_cnt - r0, sram[13'h14]} !== {32'd0, 32'hAAAA_5555}) begin
      mismatched++;
      $display("FAIL abort_noack: got resps=%0d mem=%h, required 0/aaaa5555", resp_cnt - r0, sram[13'h14]);
    end
    // master abandons cycle during ACCESS
    bus.dwb_adr_i = 32'h0000_0040; bus.dwb_cyc_i = 1'b1; bus.dwb_stb_i = 1'b1;
    @(negedge clk);
    bus.dwb_cyc_i = 1'b0; bus.dwb_stb_i = 1'b0;
    repeat (4) @(negedge clk);
    compared++;
    if (resp_cnt - r0 !== 0) begin
      mismatched++;
      $display("FAIL cyc_drop: got %0d responses, required 0", resp_cnt - r0);
    end
    push(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    do_iwb(32'h0000_0040, lat);
    compared++;
    if (lat !== 3) begin
      mismatched++;
      $display("FAIL post_abort_latency: got %0d, required 3", lat);
    end
  endtask

  initial begin
    bus.iwb_adr_i = '0; bus.iwb_cyc_i = 1'b0; bus.iwb_stb_i = 1'b0;
    bus.dwb_adr_i = '0; bus.dwb_dat_i = '0; bus.dwb_we_i = 1'b0; bus.dwb_sel_i = '0;
    bus.dwb_cyc_i = 1'b0; bus.dwb_stb_i = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 8192; i++) sram[i] = '0;
    test_reset();
    test_fetch();
    test_byte_write();
    test_contention();
    test_tohost();
    test_error_abort();
    repeat (3) @(negedge clk);
    compared++;
    if (sb.size() !== 0) begin
      mismatched++;
      $display("FAIL sb_drain: got %0d pending expectations, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
